// File: rtl/dcp_pkg.sv
// Shared types and constants for the debug command processor TX path.
// Optional macro DCP_TX_SPACE_EN adds the trailing-space state.
package dcp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND     = 3'd1,
    ST_ACK      = 3'd2,
    ST_WAIT_LOW = 3'd3
`ifdef DCP_TX_SPACE_EN
    ,
    ST_SPACE    = 3'd4
`endif
  } tx_state_e;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_SP = 8'h20;

  localparam logic TYPE_BYTE = 1'b0;
  localparam logic TYPE_WORD = 1'b1;

endpackage

// File: rtl/dcp_hex2ascii.sv
// Nibble to ASCII hex character, case selected by upper.
// Purely combinational.
module dcp_hex2ascii
  import dcp_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       upper,
  output logic [7:0] ascii
);

  // 0-9 from '0', 10-15 from 'A' or 'a'
  always_comb begin
    if (nib < 4'd10) begin
      ascii = ASCII_0 + {4'h0, nib};
    end else begin
      ascii = (upper ? ASCII_UA : ASCII_LA)
            + {4'h0, nib} - 8'd10;
    end
  end

endmodule

// File: rtl/dcp_tx_fmt.sv
// Serialises raw-byte / hex-word print requests onto a UART byte port.
// Define DCP_TX_SPACE_EN to append 0x20 after every hex word.
module dcp_tx_fmt
  import dcp_pkg::*;
#(
  parameter int HEX_DIGITS = 8,
  parameter int HEX_UPPER  = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_tx,
  input  logic        type_tx,
  input  logic [31:0] din,
  output logic        ack_tx,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic        busy
);

  localparam logic [2:0] LAST_IDX = 3'(HEX_DIGITS - 1);

  tx_state_e   st_q, st_d;
  logic [31:0] word_q, word_d;
  logic        type_q, type_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_vld_q, tx_vld_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;

  logic [31:0] src;
  logic [2:0]  idx;
  logic [3:0]  nib;
  logic [7:0]  hex_c;
  logic        upper;

  assign upper = (HEX_UPPER != 0);

  // Next digit: top digit of din on accept, else next lower latched digit
  always_comb begin
    src = (st_q == ST_IDLE) ? din : word_q;
    idx = (st_q == ST_IDLE) ? LAST_IDX : cnt_q - 3'd1;
    nib = src[{idx, 2'b00} +: 4];
  end

  dcp_hex2ascii u_hex (
    .nib   (nib),
    .upper (upper),
    .ascii (hex_c)
  );

  // Next-state and registered-output computation
  always_comb begin
    st_d      = st_q;
    word_d    = word_q;
    type_d    = type_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = tx_vld_q;
    ack_d     = 1'b0;
    busy_d    = busy_q;
    case (st_q)
      ST_IDLE: begin
        if (req_tx) begin
          st_d     = ST_SEND;
          word_d   = din;
          type_d   = type_tx;
          cnt_d    = LAST_IDX;
          tx_vld_d = 1'b1;
          busy_d   = 1'b1;
          tx_data_d = (type_tx == TYPE_BYTE)
                    ? din[7:0] : hex_c;
        end
      end
      ST_SEND: begin
        if (tx_rdy) begin
          if (type_q == TYPE_WORD && cnt_q != 3'd0) begin
            cnt_d     = cnt_q - 3'd1;
            tx_data_d = hex_c;
          end
`ifdef DCP_TX_SPACE_EN
          else if (type_q == TYPE_WORD) begin
            st_d      = ST_SPACE;
            tx_data_d = ASCII_SP;
          end
`endif
          else begin
            st_d     = ST_ACK;
            tx_vld_d = 1'b0;
            ack_d    = 1'b1;
          end
        end
      end
`ifdef DCP_TX_SPACE_EN
      ST_SPACE: begin
        if (tx_rdy) begin
          st_d     = ST_ACK;
          tx_vld_d = 1'b0;
          ack_d    = 1'b1;
        end
      end
`endif
      ST_ACK: begin
        st_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!req_tx) begin
          st_d   = ST_IDLE;
          busy_d = 1'b0;
        end
      end
      default: begin
        st_d     = ST_IDLE;
        tx_vld_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q      <= ST_IDLE;
      word_q    <= 32'h0;
      type_q    <= TYPE_BYTE;
      cnt_q     <= 3'd0;
      tx_data_q <= 8'h00;
      tx_vld_q  <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      word_q    <= word_d;
      type_q    <= type_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign ack_tx  = ack_q;
  assign tx_data = tx_data_q;
  assign tx_vld  = tx_vld_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_dcp_tx_fmt.sv
// Directed bench for dcp_tx_fmt.
// Build with DCP_TX_SPACE_EN to cover the trailing-space variant.
module tb_dcp_tx_fmt;

`ifdef DCP_TX_SPACE_EN
  localparam int UP   = 0;
  localparam int WLAT = 10;
`else
  localparam int UP   = 1;
  localparam int WLAT = 9;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_tx;
  logic        type_tx;
  logic [31:0] din;
  logic        ack_tx;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int acks  = 0;
  int stab_err = 0;
  logic [7:0] got[$];
  logic       pv = 1'b0;
  logic [7:0] pd = 8'h00;
  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  dcp_tx_fmt #(
    .HEX_DIGITS (8),
    .HEX_UPPER  (UP)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .req_tx  (req_tx),
    .type_tx (type_tx),
    .din     (din),
    .ack_tx  (ack_tx),
    .tx_data (tx_data),
    .tx_vld  (tx_vld),
    .tx_rdy  (tx_rdy),
    .busy    (busy)
  );

  always @(posedge clk) begin
    if (rstn) begin
      if (tx_vld && tx_rdy) got.push_back(tx_data);
      if (ack_tx) acks <= acks + 1;
      if (pv && (!tx_vld || tx_data !== pd))
        stab_err <= stab_err + 1;
      pv <= tx_vld && !tx_rdy;
      pd <= tx_data;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hx(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (UP != 0 ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  task automatic chk_stream(input string tag,
                            input logic t,
                            input logic [31:0] d);
    logic [7:0] e[$];
    if (t == 1'b0) begin
      e.push_back(d[7:0]);
    end else begin
      for (int k = 7; k >= 0; k--) e.push_back(hx(d[4*k +: 4]));
`ifdef DCP_TX_SPACE_EN
      e.push_back(8'h20);
`endif
    end
    chk({tag, "_len"}, got.size(), e.size());
    for (int i = 0; i < e.size() && i < got.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), {24'h0, got[i]}, {24'h0, e[i]});
  endtask

  // Starts a request at posedge+1, corrupts din/type after accept,
  // returns the cycle index of ack_tx (0 = timeout). req_tx left high.
  task automatic xfer(input logic t, input logic [31:0] d,
                      input bit toggle, output int lat);
    got.delete();
    req_tx = 1'b1;
    type_tx = t;
    din = d;
    @(posedge clk); #1;
    din = ~d;
    type_tx = ~t;
    lat = 0;
    for (int i = 1; i <= 80; i++) begin
      if (ack_tx) begin
        lat = i;
        break;
      end
      tx_rdy = toggle ? pat[i % 4] : 1'b1;
      @(posedge clk); #1;
    end
    tx_rdy = 1'b1;
    chk("ack_seen", {31'h0, ack_tx}, 32'h1);
  endtask

  task automatic settle();
    req_tx = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("idle_busy", {31'h0, busy}, 32'h0);
  endtask

  int lat;
  int a0;

  initial begin
    rstn = 1'b0;
    req_tx = 1'b0;
    type_tx = 1'b0;
    din = 32'h0;
    tx_rdy = 1'b1;
    #1;
    chk("rst_ack", {31'h0, ack_tx}, 32'h0);
    chk("rst_vld", {31'h0, tx_vld}, 32'h0);
    chk("rst_data", {24'h0, tx_data}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // raw byte 0x44, cycle-accurate
    got.delete();
    a0 = acks;
    req_tx = 1'b1;
    type_tx = 1'b0;
    din = 32'h44;
    @(posedge clk); #1;
    chk("t0_c1_vld", {31'h0, tx_vld}, 32'h1);
    chk("t0_c1_data", {24'h0, tx_data}, 32'h44);
    chk("t0_c1_busy", {31'h0, busy}, 32'h1);
    chk("t0_c1_ack", {31'h0, ack_tx}, 32'h0);
    @(posedge clk); #1;
    chk("t0_c2_ack", {31'h0, ack_tx}, 32'h1);
    chk("t0_c2_vld", {31'h0, tx_vld}, 32'h0);
    req_tx = 1'b0;
    @(posedge clk); #1;
    chk("t0_c3_ack", {31'h0, ack_tx}, 32'h0);
    chk("t0_c3_busy", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;
    chk("t0_c4_busy", {31'h0, busy}, 32'h0);
    chk_stream("t0", 1'b0, 32'h44);
    chk("t0_acks", acks - a0, 32'd1);

    // hex word, tx_rdy high
    a0 = acks;
    xfer(1'b1, 32'h1234ABCD, 1'b0, lat);
    chk("w_lat", lat, WLAT);
    settle();
    chk_stream("w", 1'b1, 32'h1234ABCD);
    chk("w_acks", acks - a0, 32'd1);
`ifndef DCP_TX_SPACE_EN
    chk("w_lit0", {24'h0, got[0]}, 32'h31);
    chk("w_lit4", {24'h0, got[4]}, 32'h41);
    chk("w_lit7", {24'h0, got[7]}, 32'h44);
`endif

    // same word with back-pressure
    a0 = acks;
    xfer(1'b1, 32'h1234ABCD, 1'b1, lat);
    settle();
    chk_stream("bp", 1'b1, 32'h1234ABCD);
    chk("bp_acks", acks - a0, 32'd1);
    chk("bp_stable", stab_err, 32'd0);

    // stale request held high after ack
    a0 = acks;
    xfer(1'b1, 32'h0, 1'b0, lat);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_vld", {31'h0, tx_vld}, 32'h0);
      chk("hold_busy", {31'h0, busy}, 32'h1);
    end
    settle();
    chk_stream("z1", 1'b1, 32'h0);
    chk("z1_acks", acks - a0, 32'd1);
    a0 = acks;
    xfer(1'b1, 32'h0, 1'b0, lat);
    settle();
    chk_stream("z2", 1'b1, 32'h0);
    chk("z2_acks", acks - a0, 32'd1);

    // reset mid-transfer
    got.delete();
    a0 = acks;
    req_tx = 1'b1;
    type_tx = 1'b1;
    din = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    chk("rm_cnt", got.size(), 32'd3);
    rstn = 1'b0;
    #1;
    chk("rm_vld", {31'h0, tx_vld}, 32'h0);
    chk("rm_ack", {31'h0, ack_tx}, 32'h0);
    chk("rm_busy", {31'h0, busy}, 32'h0);
    chk("rm_data", {24'h0, tx_data}, 32'h0);
    req_tx = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rm_noack", acks - a0, 32'd0);
    xfer(1'b1, 32'hFFFFFFFF, 1'b0, lat);
    chk("rm_lat", lat, WLAT);
    settle();
    chk_stream("rf", 1'b1, 32'hFFFFFFFF);

`ifdef DCP_TX_SPACE_EN
    xfer(1'b1, 32'h0000003A, 1'b0, lat);
    settle();
    chk("sp_len", got.size(), 32'd9);
    chk("sp_b5", {24'h0, got[5]}, 32'h30);
    chk("sp_b6", {24'h0, got[6]}, 32'h33);
    chk("sp_b7", {24'h0, got[7]}, 32'h61);
    chk("sp_b8", {24'h0, got[8]}, 32'h20);
    xfer(1'b0, 32'h0D, 1'b0, lat);
    chk("sp_t0_lat", lat, 32'd2);
    settle();
    chk_stream("sp_t0", 1'b0, 32'h0D);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
